// File: rtl/fir_tap_scheduler_pkg.sv
// Shared types, default parameters and arithmetic helpers for the FIR tap scheduler.
// The saturating round helper is also used by reference models outside the RTL.
package fir_pkg;

    typedef enum logic [2:0] {
        FLUSH,
        IDLE,
        WRITE,
        MAC,
        DRAIN,
        REDUCE,
        OUT
    } fir_state_e;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_TAPS    = 64;
    localparam int unsigned DEF_LANES   = 4;
    localparam int unsigned DEF_ACC_W   = 40;
    localparam int unsigned DEF_MAC_LAT = 2;

    function automatic int unsigned sum_width(input int unsigned acc_w, input int unsigned lanes);
        return acc_w + $clog2(lanes);
    endfunction

    // Round half up by 2^shift, then clamp to a data_w-bit two's complement range.
    function automatic logic signed [63:0] sat_round(input logic signed [63:0] sum,
                                                     input logic [4:0]         shift,
                                                     input int unsigned        data_w);
        logic signed [63:0] v;
        logic signed [63:0] lim;
        v = sum;
        if (shift != 5'd0) begin
            v = v + (64'sd1 <<< (shift - 5'd1));
        end
        v   = v >>> shift;
        lim = 64'sd1 <<< (data_w - 1);
        if (v > lim - 64'sd1) begin
            v = lim - 64'sd1;
        end else if (v < -lim) begin
            v = -lim;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_tap_scheduler_if.sv
// Sample stream interface: RX samples into the scheduler, filtered samples out to TX.
interface fir_tap_scheduler_if
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_data_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o
    );
endinterface

// File: rtl/fir_sum_scale.sv
// Lane reduction, rounding right shift and saturation, registered on en_i.
module fir_sum_scale
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned ACC_W  = DEF_ACC_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic [4:0]             shift_i,
    input  logic [LANES*ACC_W-1:0] lane_sum_i,
    output logic [DATA_W-1:0]      data_o
);
    localparam int unsigned SUM_W = sum_width(ACC_W, LANES);

    logic signed [SUM_W-1:0] sum;
    logic [DATA_W-1:0]       data_d;
    logic [DATA_W-1:0]       data_q;

    always_comb begin
        sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            sum = sum + SUM_W'(signed'(lane_sum_i[l*ACC_W +: ACC_W]));
        end
        data_d = DATA_W'(sat_round(64'(sum), shift_i, DATA_W));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/fir_tap_scheduler.sv
// Sequencer for the time-multiplexed FIR: history write, N tap steps over LANES MAC lanes,
// pipeline drain, reduce/scale, then output handshake. All outputs come from registers.
module fir_tap_scheduler
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TAPS    = DEF_TAPS,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned ACC_W   = DEF_ACC_W,
    parameter int unsigned MAC_LAT = DEF_MAC_LAT,
    localparam int unsigned N      = TAPS / LANES,
    localparam int unsigned AW     = $clog2(TAPS),
    localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fir_tap_scheduler_if.slave     strm,
    input  logic                   flush_i,
    input  logic [4:0]             cfg_shift_i,
    output logic                   buf_we_o,
    output logic [AW-1:0]          buf_waddr_o,
    output logic [DATA_W-1:0]      buf_wdata_o,
    output logic                   mac_en_o,
    output logic                   mac_clr_o,
    output logic [KW-1:0]          mac_idx_o,
    output logic [AW-1:0]          mac_base_o,
    input  logic [LANES*ACC_W-1:0] lane_sum_i,
    output logic                   busy_o
);
    localparam int unsigned DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    fir_state_e        state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [KW-1:0]     k_q, k_d;
    logic [DW-1:0]     drn_q, drn_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              buf_we_q, buf_we_d;
    logic [AW-1:0]     buf_waddr_q, buf_waddr_d;
    logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
    logic              mac_en_q, mac_en_d;
    logic              mac_clr_q, mac_clr_d;
    logic [KW-1:0]     mac_idx_q, mac_idx_d;
    logic [AW-1:0]     mac_base_q, mac_base_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    // Each register holds what is visible in the cycle after the edge that loads it, so the
    // FLUSH entry cycle (reset or flush request) issues no write and the 64 writes follow.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wptr_d      = wptr_q;
        k_d         = k_q;
        drn_d       = drn_q;
        sample_d    = sample_q;
        buf_we_d    = 1'b0;
        buf_waddr_d = buf_waddr_q;
        buf_wdata_d = buf_wdata_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        mac_idx_d   = mac_idx_q;
        mac_base_d  = mac_base_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            FLUSH: begin
                if (!cnt_q[AW]) begin
                    buf_we_d    = 1'b1;
                    buf_waddr_d = cnt_q[AW-1:0];
                    buf_wdata_d = '0;
                    cnt_d       = cnt_q + (AW+1)'(1);
                end else begin
                    wptr_d     = '0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end
            end
            IDLE: begin
                if (flush_i) begin
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = FLUSH;
                end else if (strm.in_valid_i && in_ready_q) begin
                    sample_d   = strm.in_data_i;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                buf_we_d    = 1'b1;
                buf_waddr_d = wptr_q;
                buf_wdata_d = sample_q;
                mac_base_d  = wptr_q;
                wptr_d      = wptr_q + AW'(1);
                k_d         = '0;
                state_d     = MAC;
            end
            MAC: begin
                mac_en_d  = 1'b1;
                mac_idx_d = k_q;
                mac_clr_d = (k_q == '0);
                if (k_q == KW'(N - 1)) begin
                    drn_d   = '0;
                    state_d = (MAC_LAT == 0) ? REDUCE : DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (drn_q == DW'(MAC_LAT - 1)) begin
                    state_d = REDUCE;
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            REDUCE: begin
                state_d = OUT;
            end
            OUT: begin
                out_valid_d = 1'b1;
                if (out_valid_q && strm.out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                busy_d  = 1'b1;
                state_d = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FLUSH;
            cnt_q       <= '0;
            wptr_q      <= '0;
            k_q         <= '0;
            drn_q       <= '0;
            sample_q    <= '0;
            buf_we_q    <= 1'b0;
            buf_waddr_q <= '0;
            buf_wdata_q <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_idx_q   <= '0;
            mac_base_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wptr_q      <= wptr_d;
            k_q         <= k_d;
            drn_q       <= drn_d;
            sample_q    <= sample_d;
            buf_we_q    <= buf_we_d;
            buf_waddr_q <= buf_waddr_d;
            buf_wdata_q <= buf_wdata_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            mac_idx_q   <= mac_idx_d;
            mac_base_q  <= mac_base_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Lane sums have settled by the REDUCE edge; the result register updates there.
    fir_sum_scale #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .ACC_W  (ACC_W)
    ) u_sum_scale (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (state_q == REDUCE),
        .shift_i    (cfg_shift_i),
        .lane_sum_i (lane_sum_i),
        .data_o     (strm.out_data_o)
    );

    assign strm.in_ready_o  = in_ready_q;
    assign strm.out_valid_o = out_valid_q;
    assign buf_we_o         = buf_we_q;
    assign buf_waddr_o      = buf_waddr_q;
    assign buf_wdata_o      = buf_wdata_q;
    assign mac_en_o         = mac_en_q;
    assign mac_clr_o        = mac_clr_q;
    assign mac_idx_o        = mac_idx_q;
    assign mac_base_o       = mac_base_q;
    assign busy_o           = busy_q;
endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: flush sequencing, per-sample schedule and scaled results.
module tb_fir_tap_scheduler;
    localparam int unsigned NSTEP = 16;
    localparam int unsigned NVEC  = 16;

    typedef struct {
        logic [15:0]        din;
        logic signed [39:0] l0, l1, l2, l3;
        logic [4:0]         sh;
        logic [15:0]        exp;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic [4:0]   cfg_shift;
    logic         buf_we;
    logic [5:0]   buf_waddr;
    logic [15:0]  buf_wdata;
    logic         mac_en;
    logic         mac_clr;
    logic [3:0]   mac_idx;
    logic [5:0]   mac_base;
    logic [159:0] lane_sum;
    logic         busy;

    int unsigned n_vec;
    int unsigned n_err;
    logic [5:0]  exp_addr;
    vec_t        vecs [NVEC];
    vec_t        zv;

    fir_tap_scheduler_if #(.DATA_W(16)) strm ();

    fir_tap_scheduler #(
        .DATA_W  (16),
        .TAPS    (64),
        .LANES   (4),
        .ACC_W   (40),
        .MAC_LAT (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .strm        (strm),
        .flush_i     (flush),
        .cfg_shift_i (cfg_shift),
        .buf_we_o    (buf_we),
        .buf_waddr_o (buf_waddr),
        .buf_wdata_o (buf_wdata),
        .mac_en_o    (mac_en),
        .mac_clr_o   (mac_clr),
        .mac_idx_o   (mac_idx),
        .mac_base_o  (mac_base),
        .lane_sum_i  (lane_sum),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flush();
        for (int i = 0; i < 64; i++) begin
            tick();
            check("flush_we", 64'(buf_we), 64'd1);
            check("flush_addr", 64'(buf_waddr), 64'(i));
            check("flush_data", 64'(buf_wdata), 64'd0);
            check("flush_in_ready", 64'(strm.in_ready_o), 64'd0);
        end
        tick();
        check("flush_done_in_ready", 64'(strm.in_ready_o), 64'd1);
        check("flush_done_we", 64'(buf_we), 64'd0);
        check("flush_done_busy", 64'(busy), 64'd0);
    endtask

    task automatic run_txn(input vec_t v, input int hold);
        int c;
        lane_sum  = {v.l3, v.l2, v.l1, v.l0};
        cfg_shift = v.sh;
        check("idle_in_ready", 64'(strm.in_ready_o), 64'd1);
        strm.in_valid_i = 1'b1;
        strm.in_data_i  = v.din;
        tick();
        strm.in_valid_i = 1'b0;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_in_ready", 64'(strm.in_ready_o), 64'd0);
        tick();
        check("write_we", 64'(buf_we), 64'd1);
        check("write_addr", 64'(buf_waddr), 64'(exp_addr));
        check("write_data", 64'(buf_wdata), 64'(v.din));
        check("mac_base", 64'(mac_base), 64'(exp_addr));
        for (int k = 0; k < int'(NSTEP); k++) begin
            tick();
            check("mac_en", 64'(mac_en), 64'd1);
            check("mac_idx", 64'(mac_idx), 64'(k));
            check("mac_clr", 64'(mac_clr), 64'(k == 0));
            check("mac_we_low", 64'(buf_we), 64'd0);
        end
        tick();
        check("drain_mac_en", 64'(mac_en), 64'd0);
        c = 18;
        while (!strm.out_valid_o && c < 40) begin
            tick();
            c++;
        end
        check("out_latency", 64'(c), 64'd21);
        check("out_data", 64'(strm.out_data_o), 64'(v.exp));
        for (int h = 0; h < hold; h++) begin
            strm.in_valid_i = 1'b1;
            strm.in_data_i  = 16'hBEEF;
            tick();
            check("stall_valid", 64'(strm.out_valid_o), 64'd1);
            check("stall_data", 64'(strm.out_data_o), 64'(v.exp));
            check("stall_in_ready", 64'(strm.in_ready_o), 64'd0);
            check("stall_we", 64'(buf_we), 64'd0);
        end
        strm.out_ready_i = 1'b1;
        tick();
        strm.out_ready_i = 1'b0;
        strm.in_valid_i  = 1'b0;
        check("hs_out_valid", 64'(strm.out_valid_o), 64'd0);
        check("hs_in_ready", 64'(strm.in_ready_o), 64'd1);
        check("hs_busy", 64'(busy), 64'd0);
        exp_addr = exp_addr + 6'd1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        vecs[0]  = '{16'h1234, 40'sd100, 40'sd200, 40'sd300, 40'sd400, 5'd4, 16'h003F};
        vecs[1]  = '{16'h0001, -40'sd100, -40'sd200, -40'sd300, -40'sd400, 5'd4, 16'hFFC2};
        vecs[2]  = '{16'h0002, 40'sd1073741824, 40'sd1073741824, 40'sd1073741824,
                     40'sd1073741824, 5'd0, 16'h7FFF};
        vecs[3]  = '{16'h0003, -40'sd1073741824, -40'sd1073741824, -40'sd1073741824,
                     -40'sd1073741824, 5'd0, 16'h8000};
        vecs[4]  = '{16'h0004, 40'sd3, 40'sd0, 40'sd0, 40'sd0, 5'd1, 16'h0002};
        vecs[5]  = '{16'h0005, -40'sd3, 40'sd0, 40'sd0, 40'sd0, 5'd1, 16'hFFFF};
        vecs[6]  = '{16'h0006, 40'sd32767, 40'sd0, 40'sd0, 40'sd0, 5'd0, 16'h7FFF};
        vecs[7]  = '{16'h0007, 40'sd32767, 40'sd1, 40'sd0, 40'sd0, 5'd0, 16'h7FFF};
        vecs[8]  = '{16'h0008, -40'sd32768, 40'sd0, 40'sd0, 40'sd0, 5'd0, 16'h8000};
        vecs[9]  = '{16'h0009, -40'sd32768, 40'sd0, 40'sd0, -40'sd1, 5'd0, 16'h8000};
        vecs[10] = '{16'h000A, 40'sh40_0000_0000, 40'sh40_0000_0000, 40'sh40_0000_0000,
                     40'sh40_0000_0000, 5'd31, 16'h0200};
        vecs[11] = '{16'h000B, 40'sh80_0000_0000, 40'sh80_0000_0000, 40'sh80_0000_0000,
                     40'sh80_0000_0000, 5'd31, 16'hFC00};
        vecs[12] = '{16'h000C, 40'sd1000, -40'sd500, 40'sd20, 40'sd0, 5'd2, 16'h0082};
        vecs[13] = '{16'h000D, 40'sd5, 40'sd5, 40'sd5, 40'sd5, 5'd31, 16'h0000};
        vecs[14] = '{16'h000E, 40'sd12, 40'sd0, 40'sd0, 40'sd0, 5'd3, 16'h0002};
        vecs[15] = '{16'h000F, 40'sd11, 40'sd0, 40'sd0, 40'sd0, 5'd3, 16'h0001};
        zv       = '{16'h0000, 40'sd0, 40'sd0, 40'sd0, 40'sd0, 5'd0, 16'h0000};

        rst_n            = 1'b0;
        flush            = 1'b0;
        cfg_shift        = 5'd0;
        lane_sum         = '0;
        strm.in_valid_i  = 1'b0;
        strm.in_data_i   = '0;
        strm.out_ready_i = 1'b0;
        exp_addr         = '0;

        repeat (3) tick();
        check("rst_in_ready", 64'(strm.in_ready_o), 64'd0);
        check("rst_out_valid", 64'(strm.out_valid_o), 64'd0);
        check("rst_out_data", 64'(strm.out_data_o), 64'd0);
        check("rst_we", 64'(buf_we), 64'd0);
        check("rst_mac_en", 64'(mac_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        #3 rst_n = 1'b1;
        check_flush();

        for (int i = 0; i < int'(NVEC); i++) begin
            run_txn(vecs[i], 0);
        end
        run_txn(vecs[0], 10);

        // Fill the history until the 65th write wraps to address 0.
        while (exp_addr != 6'd0) begin
            run_txn(zv, 0);
        end
        run_txn(vecs[4], 0);

        flush           = 1'b1;
        strm.in_valid_i = 1'b1;
        strm.in_data_i  = 16'h5555;
        tick();
        flush           = 1'b0;
        strm.in_valid_i = 1'b0;
        check("flushreq_in_ready", 64'(strm.in_ready_o), 64'd0);
        check("flushreq_busy", 64'(busy), 64'd1);
        check("flushreq_we", 64'(buf_we), 64'd0);
        check_flush();
        exp_addr = '0;
        run_txn(vecs[12], 0);

        lane_sum        = '0;
        strm.in_valid_i = 1'b1;
        strm.in_data_i  = 16'h7777;
        tick();
        strm.in_valid_i = 1'b0;
        repeat (3) tick();
        check("midmac_active", 64'(mac_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mac_en", 64'(mac_en), 64'd0);
        check("midrst_mac_base", 64'(mac_base), 64'd0);
        check("midrst_mac_idx", 64'(mac_idx), 64'd0);
        check("midrst_busy", 64'(busy), 64'd1);
        check("midrst_out_data", 64'(strm.out_data_o), 64'd0);
        tick();
        check("midrst_we", 64'(buf_we), 64'd0);
        check("midrst_out_valid", 64'(strm.out_valid_o), 64'd0);
        check("midrst_in_ready", 64'(strm.in_ready_o), 64'd0);
        #3 rst_n = 1'b1;
        check_flush();
        exp_addr = '0;
        run_txn(vecs[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
